pb_autorepeat_mc: RTL

PB_AUTOREPEAT_MC -- requirements
Module: pb_autorepeat_mc

---
 rtl/pb_pkg.sv | 25 ++
 rtl/pb_channel_fsm.sv | 105 ++++++++++
 rtl/pb_autorepeat_mc.sv | 39 +++
 3 files changed

// File: rtl/pb_pkg.sv
// Shared types and constants for the multi-channel push-button auto-repeat block.
package pb_pkg;

    typedef logic [2:0] pb_state_t;

    localparam pb_state_t ST_IDLE        = 3'd0;
    localparam pb_state_t ST_PRESSED     = 3'd1;
    localparam pb_state_t ST_TAP_PULSE   = 3'd2;
    localparam pb_state_t ST_HOLD_PULSE  = 3'd3;
    localparam pb_state_t ST_REPEAT_WAIT = 3'd4;
    localparam pb_state_t ST_LATCHED     = 3'd5;

    // Smallest legal delay/period and channel count.
    localparam int unsigned PB_MIN_DELAY    = 2;
    localparam int unsigned PB_MIN_CHANNELS = 1;

    function automatic int unsigned pb_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pb_channel_fsm.sv
// One push-button channel: tap detection, hold detection and two-speed auto-repeat.
module pb_channel_fsm
    import pb_pkg::*;
#(
    parameter int unsigned N_HOLD_DELAY      = 50_000_000,
    parameter int unsigned N_REPEAT_PERIOD   = 25_000_000,
    parameter int unsigned N_FAST_PERIOD     = 5_000_000,
    parameter int unsigned N_REPEATS_TO_FAST = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic pb_status,
    input  logic repeat_en,
    output logic inc_pulse,
    output logic held
);

    localparam int unsigned MAX_DELAY = pb_max3(N_HOLD_DELAY, N_REPEAT_PERIOD, N_FAST_PERIOD);
    localparam int unsigned TW        = $clog2(MAX_DELAY) + 1;
    localparam int unsigned RW        = (N_REPEATS_TO_FAST > 0) ? $clog2(N_REPEATS_TO_FAST + 1) : 1;

    // Timers count down to zero; a state lasting P cycles is loaded with P-2
    // because the entry cycle and the exit decision each consume one cycle.
    localparam logic [TW-1:0] HOLD_LD = TW'(N_HOLD_DELAY - 2);
    localparam logic [TW-1:0] SLOW_LD = TW'(N_REPEAT_PERIOD - 2);
    localparam logic [TW-1:0] FAST_LD = TW'(N_FAST_PERIOD - 2);
    localparam logic [RW-1:0] REP_MAX = RW'(N_REPEATS_TO_FAST);

    if (N_HOLD_DELAY < PB_MIN_DELAY || N_REPEAT_PERIOD < PB_MIN_DELAY ||
        N_FAST_PERIOD < PB_MIN_DELAY || N_FAST_PERIOD > N_REPEAT_PERIOD) begin : g_bad_params
        $error("pb_channel_fsm: illegal delay/period parameters");
    end

    pb_state_t     state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [RW-1:0] rep, rep_nxt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            rep       <= '0;
            inc_pulse <= 1'b0;
            held      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            rep       <= rep_nxt;
            inc_pulse <= (state_nxt == ST_TAP_PULSE) || (state_nxt == ST_HOLD_PULSE);
            held      <= (state_nxt == ST_HOLD_PULSE) || (state_nxt == ST_REPEAT_WAIT) ||
                         (state_nxt == ST_LATCHED);
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        rep_nxt   = rep;

        case (state)
            ST_IDLE: begin
                if (pb_status) state_nxt = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!pb_status)      state_nxt = ST_TAP_PULSE;
                else if (tmr == '0)  state_nxt = ST_HOLD_PULSE;
                else                 tmr_nxt   = tmr - TW'(1);
            end
            ST_TAP_PULSE: begin
                state_nxt = ST_IDLE;
            end
            ST_HOLD_PULSE: begin
                if (!pb_status)     state_nxt = ST_IDLE;
                else if (repeat_en) state_nxt = ST_REPEAT_WAIT;
                else                state_nxt = ST_LATCHED;
            end
            ST_REPEAT_WAIT: begin
                if (!pb_status)      state_nxt = ST_IDLE;
                else if (!repeat_en) state_nxt = ST_LATCHED;
                else if (tmr == '0) begin
                    state_nxt = ST_HOLD_PULSE;
                    if (rep < REP_MAX) rep_nxt = rep + RW'(1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            ST_LATCHED: begin
                if (!pb_status) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Reload the timer for whatever state is being entered.
        if (state_nxt != state) begin
            case (state_nxt)
                ST_PRESSED:     tmr_nxt = HOLD_LD;
                ST_REPEAT_WAIT: tmr_nxt = (rep < REP_MAX) ? SLOW_LD : FAST_LD;
                default:        tmr_nxt = '0;
            endcase
        end

        if (state_nxt == ST_IDLE) rep_nxt = '0;
    end

endmodule

// File: rtl/pb_autorepeat_mc.sv
// Array of independent push-button auto-repeat channels.
module pb_autorepeat_mc
    import pb_pkg::*;
#(
    parameter int unsigned N_CHANNELS        = 4,
    parameter int unsigned N_HOLD_DELAY      = 50_000_000,
    parameter int unsigned N_REPEAT_PERIOD   = 25_000_000,
    parameter int unsigned N_FAST_PERIOD     = 5_000_000,
    parameter int unsigned N_REPEATS_TO_FAST = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [N_CHANNELS-1:0] PB_status,
    input  logic [N_CHANNELS-1:0] repeat_en,
    output logic [N_CHANNELS-1:0] IncPulse_out,
    output logic [N_CHANNELS-1:0] held_out
);

    if (N_CHANNELS < PB_MIN_CHANNELS) begin : g_bad_channels
        $error("pb_autorepeat_mc: N_CHANNELS must be at least 1");
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        pb_channel_fsm #(
            .N_HOLD_DELAY      (N_HOLD_DELAY),
            .N_REPEAT_PERIOD   (N_REPEAT_PERIOD),
            .N_FAST_PERIOD     (N_FAST_PERIOD),
            .N_REPEATS_TO_FAST (N_REPEATS_TO_FAST)
        ) u_ch (
            .clk       (clk),
            .resetN    (resetN),
            .pb_status (PB_status[i]),
            .repeat_en (repeat_en[i]),
            .inc_pulse (IncPulse_out[i]),
            .held      (held_out[i])
        );
    end

endmodule
